// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and address-field width helpers for the
//               direct-mapped write-back cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_t;

    // Byte-offset bits inside one line (one memory beat).
    function automatic int off_bits(input int mem_w);
        return $clog2(mem_w / 8);
    endfunction

    // Byte-offset bits inside one CPU word (ignored by the cache).
    function automatic int byte_bits(input int cpu_w);
        return $clog2(cpu_w / 8);
    endfunction

    // Word-select width; kept at least 1 so the select signal always exists.
    function automatic int word_bits(input int mem_w, input int cpu_w);
        return (mem_w / cpu_w > 1) ? $clog2(mem_w / cpu_w) : 1;
    endfunction

    function automatic int idx_bits(input int n);
        return $clog2(n);
    endfunction

    function automatic int tag_bits(input int addr_w, input int mem_w, input int n);
        return addr_w - off_bits(mem_w) - idx_bits(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_store
// Description : Valid/dirty/tag/data arrays for the cache. Asynchronous read
//               at i_idx, a single-word write port and a full-line fill port,
//               both committed at posedge. Only valid and dirty are reset.
// Ports       : i_idx          - line index for read and both write ports
//               o_valid/o_dirty/o_tag/o_line - contents of the indexed line
//               i_word_we/i_word_sel/i_word_data - CPU store into the line
//               i_fill_we/i_fill_tag/i_fill_line - refill from memory
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_store #(
    parameter int NUM_LINES = 512,
    parameter int LINE_W    = 64,
    parameter int WORD_W    = 32,
    parameter int IDX_W     = 9,
    parameter int TAG_W     = 20,
    parameter int SEL_W     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_idx,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_line,
    input  logic              i_word_we,
    input  logic [SEL_W-1:0]  i_word_sel,
    input  logic [WORD_W-1:0] i_word_data,
    input  logic              i_fill_we,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic [LINE_W-1:0] i_fill_line
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_line [NUM_LINES];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_line[i_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a cleared valid bit masks their contents.
    always_ff @(posedge clk) begin
        if (i_fill_we) begin
            r_tag[i_idx]  <= i_fill_tag;
            r_line[i_idx] <= i_fill_line;
        end else if (i_word_we) begin
            r_line[i_idx][int'(i_word_sel)*WORD_W +: WORD_W] <= i_word_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache.sv
`default_nettype none
// ============================================================================
// Module      : cache
// Description : Direct-mapped, write-back, write-allocate cache. Hits finish
//               in the request cycle; misses stall via busy while the FSM
//               writes back a dirty victim and refills the line.
// Ports       : clk, rst (async, active-high)
//               CPU side : addr, w_data, r_data, re, we, busy, done
//               Mem side : mem_addr, mem_r_data, mem_w_data, mem_re, mem_we,
//                          mem_busy, mem_done
// Revision    : 1.0 - initial release
// ============================================================================
module cache
    import cache_pkg::*;
#(
    parameter int AddrBusWidth  = 32,
    parameter int CacheBusWidth = 32,
    parameter int MemBusWidth   = 64,
    parameter int N             = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AddrBusWidth-1:0]  addr,
    input  logic [CacheBusWidth-1:0] w_data,
    output logic [CacheBusWidth-1:0] r_data,
    input  logic                     re,
    input  logic                     we,
    output logic                     busy,
    output logic                     done,
    output logic [AddrBusWidth-1:0]  mem_addr,
    input  logic [MemBusWidth-1:0]   mem_r_data,
    output logic [MemBusWidth-1:0]   mem_w_data,
    output logic                     mem_re,
    output logic                     mem_we,
    input  logic                     mem_busy,
    input  logic                     mem_done
);

    localparam int OFF_W  = off_bits(MemBusWidth);
    localparam int BYTE_W = byte_bits(CacheBusWidth);
    localparam int SEL_W  = word_bits(MemBusWidth, CacheBusWidth);
    localparam int IDX_W  = idx_bits(N);
    localparam int TAG_W  = tag_bits(AddrBusWidth, MemBusWidth, N);
    localparam int WORDS  = MemBusWidth / CacheBusWidth;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic [SEL_W-1:0]       w_sel;
    logic                   w_valid;
    logic                   w_dirty;
    logic [TAG_W-1:0]       w_line_tag;
    logic [MemBusWidth-1:0] w_line;
    logic                   w_req;
    logic                   w_hit;
    logic                   w_word_we;
    logic                   w_fill_we;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_mem_re;
    logic                   w_mem_we;
    logic [AddrBusWidth-1:0] w_mem_addr;
    logic [MemBusWidth-1:0]  w_mem_w_data;

    assign w_idx = addr[OFF_W +: IDX_W];
    assign w_tag = addr[AddrBusWidth-1 -: TAG_W];

    generate
        if (WORDS > 1) begin : g_sel
            assign w_sel = addr[BYTE_W +: SEL_W];
        end else begin : g_sel_single
            assign w_sel = '0;
        end
        // The sub-word byte bits never affect a CPU-word access.
        if (BYTE_W > 0) begin : g_byte_lo
            logic w_unused_byte_lo;
            assign w_unused_byte_lo = ^addr[BYTE_W-1:0];
        end
    endgenerate

    cache_line_store #(
        .NUM_LINES (N),
        .LINE_W    (MemBusWidth),
        .WORD_W    (CacheBusWidth),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .SEL_W     (SEL_W)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .i_idx       (w_idx),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_line_tag),
        .o_line      (w_line),
        .i_word_we   (w_word_we),
        .i_word_sel  (w_sel),
        .i_word_data (w_data),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (w_tag),
        .i_fill_line (mem_r_data)
    );

    assign w_req = re | we;
    assign w_hit = w_valid && (w_line_tag == w_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_w_data = '0;
        w_word_we    = 1'b0;
        w_fill_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_done    = 1'b1;
                        w_word_we = we;
                    end else begin
                        w_busy      = 1'b1;
                        w_state_nxt = (w_valid && w_dirty) ? ST_WRITEBACK : ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                w_busy       = 1'b1;
                w_mem_addr   = {w_line_tag, w_idx, {OFF_W{1'b0}}};
                w_mem_w_data = w_line;
                if (!mem_busy) begin
                    w_mem_we = 1'b1;
                    if (mem_done) begin
                        w_state_nxt = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                w_busy     = 1'b1;
                w_mem_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
                if (!mem_busy) begin
                    w_mem_re = 1'b1;
                    if (mem_done) begin
                        // Always return to IDLE so the memory strobes drop for a cycle.
                        w_fill_we   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset forces the state to IDLE asynchronously; the remaining IDLE
    // outputs depend on the held CPU request, so they are masked as well.
    assign busy       = w_busy & ~rst;
    assign done       = w_done & ~rst;
    assign mem_re     = w_mem_re & ~rst;
    assign mem_we     = w_mem_we & ~rst;
    assign mem_addr   = rst ? '0 : w_mem_addr;
    assign mem_w_data = rst ? '0 : w_mem_w_data;
    assign r_data     = rst ? '0 : w_line[int'(w_sel)*CacheBusWidth +: CacheBusWidth];

endmodule
`default_nettype wire

// File: tb/tb_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache
// Description : Directed self-checking bench for the cache: cold miss,
//               hits, store hit, dirty eviction, memory back-pressure and
//               reset during a refill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        re;
    logic        we;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic [63:0] mem_r_data;
    logic [63:0] mem_w_data;
    logic        mem_re;
    logic        mem_we;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_ack;

    int n_pass;
    int n_total;

    // Zero-latency memory when mem_ack is set.
    assign mem_done = mem_ack & (mem_re | mem_we);

    cache dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .w_data     (w_data),
        .r_data     (r_data),
        .re         (re),
        .we         (we),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_r_data (mem_r_data),
        .mem_w_data (mem_w_data),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        addr       = 32'h0000_1004;
        w_data     = '0;
        re         = 1'b1;
        we         = 1'b0;
        mem_busy   = 1'b0;
        mem_ack    = 1'b0;
        mem_r_data = '0;

        // Reset with a request already present: everything quiet.
        tick();
        tick();
        chk("rst_busy",   busy,       0);
        chk("rst_done",   done,       0);
        chk("rst_mem_re", mem_re,     0);
        chk("rst_mem_we", mem_we,     0);
        chk("rst_rdata",  r_data,     0);
        chk("rst_maddr",  mem_addr,   0);
        chk("rst_mwdata", mem_w_data, 0);

        // Cold read miss on 0x1004.
        rst = 1'b0;
        #1;
        chk("cold_busy",   busy,   1);
        chk("cold_done",   done,   0);
        chk("cold_mem_re0", mem_re, 0);
        tick();
        chk("cold_mem_re", mem_re,   1);
        chk("cold_mem_we", mem_we,   0);
        chk("cold_maddr",  mem_addr, 32'h0000_1000);
        chk("cold_busy2",  busy,     1);
        mem_ack    = 1'b1;
        mem_r_data = 64'hAAAA_AAAA_BBBB_BBBB;
        tick();
        chk("cold_done2",  done,   1);
        chk("cold_busy3",  busy,   0);
        chk("cold_rdata",  r_data, 32'hAAAA_AAAA);
        chk("cold_idle_re", mem_re, 0);

        // Hit on the other word of the same line.
        addr = 32'h0000_1000;
        #1;
        chk("hit_done",  done,   1);
        chk("hit_rdata", r_data, 32'hBBBB_BBBB);
        chk("hit_mem_re", mem_re, 0);

        // Store hit, then read it back.
        re     = 1'b0;
        we     = 1'b1;
        w_data = 32'h1234_5678;
        #1;
        chk("wr_done", done, 1);
        chk("wr_busy", busy, 0);
        tick();
        we = 1'b0;
        re = 1'b1;
        #1;
        chk("rb_done",   done,   1);
        chk("rb_rdata",  r_data, 32'h1234_5678);
        chk("rb_mem_re", mem_re, 0);
        chk("rb_mem_we", mem_we, 0);

        // Conflict miss with a dirty victim: writeback then refill.
        addr = 32'h0000_2000;
        #1;
        chk("evict_busy", busy, 1);
        chk("evict_done", done, 0);
        tick();
        chk("wb_mem_we",  mem_we,     1);
        chk("wb_mem_re",  mem_re,     0);
        chk("wb_maddr",   mem_addr,   32'h0000_1000);
        chk("wb_mwdata",  mem_w_data, 64'hAAAA_AAAA_1234_5678);
        chk("wb_busy",    busy,       1);
        mem_r_data = 64'h1111_1111_2222_2222;
        tick();
        chk("rf_mem_re",  mem_re,   1);
        chk("rf_mem_we",  mem_we,   0);
        chk("rf_maddr",   mem_addr, 32'h0000_2000);
        tick();
        chk("evict_done2", done,   1);
        chk("evict_rdata", r_data, 32'h2222_2222);

        // Memory back-pressure during a refill of 0x3008.
        mem_busy = 1'b1;
        addr     = 32'h0000_3008;
        mem_r_data = 64'h3333_3333_4444_4444;
        #1;
        chk("bp_busy0", busy, 1);
        tick();
        chk("bp_re1",   mem_re, 0);
        chk("bp_busy1", busy,   1);
        tick();
        chk("bp_re2",   mem_re, 0);
        chk("bp_busy2", busy,   1);
        tick();
        chk("bp_re3",   mem_re, 0);
        chk("bp_busy3", busy,   1);
        mem_busy = 1'b0;
        #1;
        chk("bp_re_rise", mem_re,   1);
        chk("bp_maddr",   mem_addr, 32'h0000_3008);
        tick();
        chk("bp_done",  done,   1);
        chk("bp_rdata", r_data, 32'h4444_4444);

        // Reset in the middle of a refill of 0x400C.
        mem_ack = 1'b0;
        addr    = 32'h0000_400C;
        tick();
        chk("mr_mem_re", mem_re, 1);
        rst = 1'b1;
        #1;
        chk("mr_rst_re",    mem_re,   0);
        chk("mr_rst_busy",  busy,     0);
        chk("mr_rst_done",  done,     0);
        chk("mr_rst_maddr", mem_addr, 0);
        chk("mr_rst_rdata", r_data,   0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_miss_busy", busy, 1);
        chk("mr_miss_done", done, 0);
        tick();
        chk("mr_re",    mem_re,   1);
        chk("mr_maddr", mem_addr, 32'h0000_4008);
        mem_ack    = 1'b1;
        mem_r_data = 64'h5555_5555_6666_6666;
        tick();
        chk("mr_done",  done,   1);
        chk("mr_rdata", r_data, 32'h5555_5555);

        // Earlier lines were invalidated by reset.
        addr = 32'h0000_2000;
        #1;
        chk("mr_old_miss", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache.md
Name: cache

Overview:
- Direct-mapped, write-back, write-allocate cache between a 32-bit CPU load/store port and a wider memory bus.
- Each line is one memory-bus beat (MemBusWidth bits).
- Hits complete in the request cycle.
- Misses stall the CPU via busy while the FSM writes back a dirty victim, if any, and then refills the line.

Parameters:
- AddrBusWidth, 32, byte-address width on both ports.
- CacheBusWidth, 32, CPU data width; must divide MemBusWidth.
- MemBusWidth, 64, memory data width and line size in bits.
- N, 512, number of lines; must be a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- addr  in  AddrBusWidth  CPU byte address
- w_data  in  CacheBusWidth  store data
- r_data  out  CacheBusWidth  load data
- re  in  1  read request
- we  in  1  write request
- busy  out  1  request not yet serviceable; CPU must hold addr, w_data, re and we
- done  out  1  request completes this cycle
- mem_addr  out  AddrBusWidth  line-aligned memory address
- mem_r_data  in  MemBusWidth  refill data
- mem_w_data  out  MemBusWidth  write-back data
- mem_re  out  1  refill request
- mem_we  out  1  write-back request
- mem_busy  in  1  memory not ready to accept a new request
- mem_done  in  1  memory completes the current request (may be combinational from mem_re/mem_we)

Behaviour:
- Address split:
  - OFF = log2(MemBusWidth/8) low bits.
  - Word select = bits [OFF-1 : log2(CacheBusWidth/8)]; the lowest log2(CacheBusWidth/8) bits are ignored.
  - Index = next log2(N) bits (default [11:3]).
  - Tag = remaining upper bits (default [31:12]).
- Per line: valid bit, dirty bit, tag, MemBusWidth data. Arrays have asynchronous read and are written at posedge.
- States: IDLE, WRITEBACK, REFILL.
- hit = valid[idx] && tag[idx]==addr tag.
- IDLE, req = re|we:
  - req && hit:
    - done=1 and busy=0 combinationally.
    - r_data = selected word of the line.
    - If we: the selected word is written with w_data at posedge and dirty is set.
    - we has priority over re when both are high (write performed; r_data shows the old word).
  - req && !hit: busy=1 combinationally, done=0. At posedge go to WRITEBACK if the victim is valid && dirty, else REFILL.
  - No req: busy=0, done=0.
- WRITEBACK:
  - mem_we=1 while mem_busy=0.
  - mem_addr = {victim tag, idx, OFF zeros}; mem_w_data = victim line.
  - On posedge with mem_done=1: go to REFILL.
- REFILL:
  - mem_re=1 while mem_busy=0; mem_addr = {req tag, idx, OFF zeros}.
  - On posedge with mem_done=1: line data <= mem_r_data, tag updated, valid=1, dirty=0; go to IDLE.
  - The held request then hits in the following cycle.
- busy=1 in WRITEBACK and REFILL; done=0 in both.
- mem_re and mem_we are never both high.
- mem_re and mem_we deassert for at least one cycle between successive requests: IDLE is always re-entered after a refill.
- mem_busy=1 suppresses mem_re/mem_we and holds the current state.
- Miss latency: 2 cycles from accept to done with a clean victim and a zero-latency memory; 3 cycles with a dirty victim.
- Reset, including mid-miss:
  - State IDLE; all valid and dirty bits cleared; in-flight request abandoned.
  - Outputs: busy=0, done=0, mem_re=0, mem_we=0, r_data=0, mem_addr=0, mem_w_data=0.
- Data and tag arrays are not reset.

Decomposition:
- Package cache_pkg holds:
  - state enum (IDLE, WRITEBACK, REFILL);
  - localparam functions for OFF/word/index/tag bit widths derived from the parameters.
- Sub-module cache_line_store holds valid, dirty, tag and data arrays:
  - asynchronous read port at index;
  - a word-write port;
  - a full-line fill port.
- The top level holds the FSM, hit logic and muxing.

Test Plan:
- Cold read 0x00001004 -> busy=1; mem_re=1 with mem_addr=0x00001000. Memory returns 0xAAAAAAAA_BBBBBBBB with mem_done. Next cycle done=1, r_data=0xAAAAAAAA.
- Re-read 0x00001000 -> done=1 in the request cycle, r_data=0xBBBBBBBB, mem_re stays 0.
- Write 0x00001000 data 0x12345678 (hit) -> done=1. Then read 0x00001000 returns 0x12345678 with no memory traffic.
- Conflict read 0x00002000 (same index) after that dirty write -> mem_we=1, mem_addr=0x00001000, mem_w_data=0xAAAAAAAA_12345678. Then mem_re=1, mem_addr=0x00002000. Then done=1.
- Hold mem_busy=1 for 3 cycles during a miss -> mem_re stays 0 and busy stays 1. mem_re rises when mem_busy drops.
- Assert rst during REFILL -> mem_re=0 and busy=0 immediately. A later read of the same address misses again.
